imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Registered, parametrised successor to the single-cycle immediate extender. It accepts instr[31:7] plus a 3-bit immediate-type select over a valid/ready handshake. It produces a sign- or zero-extended XLEN-wide immediate one cycle later, with a 2-entry (output + skid) buffer so it can sit between the fetch/decode pipeline registers at full throughput. It adds U-type, shift-amount and CSR-uimm modes, 64-bit support, a passthrough tag and an illegal-select flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only.
TAG_W, 32, width of the sideband tag (PC or rd index) carried alongside each immediate.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  upstream item present
in_ready  output  1  block can accept an item this cycle
instruction  input  25  instruction bits [31:7] (index 31 down to 7)
ImmSrc  input  3  immediate type select
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  ImmExt/out_tag/out_illegal valid
out_ready  input  1  downstream accepts this cycle
ImmExt  output  XLEN  extended immediate
out_tag  output  TAG_W  tag matching ImmExt
out_illegal  output  1  ImmSrc was reserved (3'b111)

Behaviour:
- Reset (rst_n low at posedge): out_valid=0, skid_valid=0, in_ready=1, ImmExt=0, out_tag=0, out_illegal=0. Reset overrides any simultaneous handshake; buffered items are discarded.
- Decode, with i = instruction and S = sign bit i[31]. Results are sign-extended to XLEN unless stated otherwise:
  - 000 I: {S.., i[31:20]}
  - 001 S: {S.., i[31:25], i[11:7]}
  - 010 B: {S.., i[7], i[30:25], i[11:8], 1'b0}
  - 011 J: {S.., i[19:12], i[20], i[30:21], 1'b0}
  - 100 U: {S.., i[31:12], 12'b0}; for XLEN=64, bits 63:32 replicate i[31].
  - 101 shamt: zero-extend i[24:20] when XLEN=32, i[25:20] when XLEN=64.
  - 110 CSR uimm: zero-extend i[19:15].
  - 111 reserved: ImmExt=0, out_illegal=1.
  - out_illegal=0 for every other code.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
  - Output stage loads when it is empty or transferring. Source is the skid entry if skid_valid, else the accepted input.
  - If an accept occurs while the output stage holds (out_valid & !out_ready), the decoded item goes to the skid entry and skid_valid is set.
  - Skid drains into the output stage on the next output transfer.
- Latency: accepted item appears on ImmExt/out_valid at the next posedge (1 cycle) when not back-pressured.
- Throughput: 1 item/cycle with out_ready held high.
- Ordering: strict FIFO.
- Outputs stay stable while out_valid & !out_ready.
- Capacity: 2 items (output + skid). With both full, in_ready=0 and the input is ignored.
- out_valid falls only after a transfer with no replacement item available.
- Decode is purely combinational on the accept path; registered outputs only.
- XLEN outside {32,64} is a configuration error and must fail elaboration.

Test Plan:
1. Single-item decode, XLEN=32, out_ready=1, instruction = bits [31:7] with only i[31]=1:
   - ImmSrc 000 -> ImmExt=0xFFFFF800
   - 001 -> 0xFFFFF800
   - 010 -> 0xFFFFF000
   - 011 -> 0xFFF00000
   - 100 -> 0x80000000
   - Each result appears exactly 1 cycle after accept.
2. Real encodings:
   - addi word 0xFFF00093, ImmSrc 000 -> 0xFFFFFFFF.
   - sw word 0xFE112E23, ImmSrc 001 -> 0xFFFFFFFC.
   - csrrwi with i[19:15]=5'b10101, ImmSrc 110 -> 0x00000015.
   - ImmSrc 111 -> ImmExt=0, out_illegal=1.
3. Backpressure: hold out_ready=0, present tags A, B, C back-to-back.
   - A is in the output stage, B in skid, in_ready=0; C is not accepted.
   - Raise out_ready: A, B, C emerge in order on consecutive cycles with stable outputs while stalled.
4. Streaming: 16 consecutive items with in_valid=out_ready=1 -> 16 outputs on 16 consecutive cycles, tags in order, in_ready constantly 1.
5. Reset mid-operation: output and skid both full, drive rst_n=0 for one edge -> out_valid=0, in_ready=1, ImmExt=0. The first item after reset emerges normally 1 cycle after accept.
6. XLEN=64:
   - i[31]=1, ImmSrc 100 -> 0xFFFFFFFF80000000.
   - ImmSrc 101 with i[25:20]=6'b111111 -> 0x000000000000003F; the bit-25 contribution is checked.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with valid/ready handshake and a one-entry skid buffer
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instruction,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  generate
    if (XLEN != 32 && XLEN != 64) begin : gXlenCheck
      $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
  endgenerate
  logic            sign;
  logic [XLEN-1:0] decImm;
  logic            decIll;
  logic            skidValid;
  logic [XLEN-1:0] skidImm;
  logic [TAG_W-1:0] skidTag;
  logic            skidIll;
  logic            accept;
  logic            load;
  always_comb begin
    sign   = instruction[31];
    decIll = ImmSrc == 3'b111;
    case (ImmSrc)
      3'b000:  decImm = {{(XLEN-12){sign}}, instruction[31:20]};
      3'b001:  decImm = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
      3'b010:  decImm = {{(XLEN-12){sign}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      3'b011:  decImm = {{(XLEN-20){sign}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      3'b100:  decImm = {{(XLEN-31){sign}}, instruction[30:12], 12'b0};
      3'b101:  decImm = XLEN'({instruction[25] & (XLEN == 64), instruction[24:20]});
      3'b110:  decImm = XLEN'(instruction[19:15]);
      default: decImm = '0;
    endcase
  end
  assign in_ready = !skidValid;
  assign accept   = in_valid & in_ready;
  assign load     = !out_valid | out_ready;
  // skid only fills while the output stage stalls, so it always drains first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      skidValid   <= 1'b0;
      ImmExt      <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      skidImm     <= '0;
      skidTag     <= '0;
      skidIll     <= 1'b0;
    end else if (load) begin
      out_valid <= skidValid | accept;
      if (skidValid) begin
        ImmExt      <= skidImm;
        out_tag     <= skidTag;
        out_illegal <= skidIll;
        skidValid   <= 1'b0;
      end else if (accept) begin
        ImmExt      <= decImm;
        out_tag     <= in_tag;
        out_illegal <= decIll;
      end
    end else if (accept) begin
      skidImm   <= decImm;
      skidTag   <= in_tag;
      skidIll   <= decIll;
      skidValid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: vector table plus scoreboard checks for imm_extend_pipe at XLEN 32 and 64
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        inValid = 1'b0, outReady = 1'b1;
  logic        inReady, outValid, outIll;
  logic [31:7] instr = '0;
  logic [2:0]  src = '0;
  logic [31:0] inTag = '0;
  logic [31:0] outTag, immOut;
  logic        v64 = 1'b0;
  logic        rdy64, ov64, ill64;
  logic [31:7] instr64 = '0;
  logic [2:0]  src64 = '0;
  logic [7:0]  tag64 = '0;
  logic [7:0]  otag64;
  logic [63:0] imm64;
  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .instruction(instr), .ImmSrc(src), .in_tag(inTag), .out_valid(outValid),
    .out_ready(outReady), .ImmExt(immOut), .out_tag(outTag), .out_illegal(outIll)
  );
  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
    .instruction(instr64), .ImmSrc(src64), .in_tag(tag64), .out_valid(ov64),
    .out_ready(1'b1), .ImmExt(imm64), .out_tag(otag64), .out_illegal(ill64)
  );
  typedef struct { logic [31:0] imm; logic [31:0] tag; logic ill; } exp_t;
  typedef struct { logic [31:0] w; logic [2:0] s; logic [63:0] e; logic il; } vec_t;
  exp_t sb[$];
  exp_t cur, popped;
  vec_t vt[15];
  vec_t v6[5];
  int nVec = 0, nErr = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] w, input logic [2:0] s, input logic [31:0] t,
                       input logic [31:0] e, input logic il);
    inValid = 1'b1;
    instr = w[31:7];
    src = s;
    inTag = t;
    cur.imm = e;
    cur.tag = t;
    cur.ill = il;
  endtask
  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          nVec++;
          nErr++;
          $display("FAIL unexpected_output: tag %h with empty scoreboard", outTag);
        end else begin
          popped = sb.pop_front();
          chk("sb_imm", 64'(immOut), 64'(popped.imm));
          chk("sb_tag", 64'(outTag), 64'(popped.tag));
          chk("sb_illegal", 64'(outIll), 64'(popped.ill));
        end
      end
      if (inValid && inReady) sb.push_back(cur);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    logic [31:0] w;
    vt[0]  = '{32'h80000000, 3'b000, 64'hFFFFF800, 1'b0};
    vt[1]  = '{32'h80000000, 3'b001, 64'hFFFFF800, 1'b0};
    vt[2]  = '{32'h80000000, 3'b010, 64'hFFFFF000, 1'b0};
    vt[3]  = '{32'h80000000, 3'b011, 64'hFFF00000, 1'b0};
    vt[4]  = '{32'h80000000, 3'b100, 64'h80000000, 1'b0};
    vt[5]  = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 1'b0};
    vt[6]  = '{32'hFE112E23, 3'b001, 64'hFFFFFFFC, 1'b0};
    vt[7]  = '{32'h000AD073, 3'b110, 64'h00000015, 1'b0};
    vt[8]  = '{32'hFFFFFFFF, 3'b111, 64'h00000000, 1'b1};
    vt[9]  = '{32'h03F00000, 3'b101, 64'h0000001F, 1'b0};
    vt[10] = '{32'h7FF00093, 3'b000, 64'h000007FF, 1'b0};
    vt[11] = '{32'h7FFFF000, 3'b011, 64'h000FFFFE, 1'b0};
    vt[12] = '{32'h7E000F80, 3'b010, 64'h00000FFE, 1'b0};
    vt[13] = '{32'h12345000, 3'b100, 64'h12345000, 1'b0};
    vt[14] = '{32'hFFFFFFFF, 3'b110, 64'h0000001F, 1'b0};
    v6[0]  = '{32'h80000000, 3'b100, 64'hFFFFFFFF80000000, 1'b0};
    v6[1]  = '{32'h03F00000, 3'b101, 64'h000000000000003F, 1'b0};
    v6[2]  = '{32'h02000000, 3'b101, 64'h0000000000000020, 1'b0};
    v6[3]  = '{32'h80000000, 3'b000, 64'hFFFFFFFFFFFFF800, 1'b0};
    v6[4]  = '{32'hFFFFFFFF, 3'b111, 64'h0000000000000000, 1'b1};
    step();
    step();
    chk("reset_out_valid", 64'(outValid), 64'd0);
    chk("reset_in_ready", 64'(inReady), 64'd1);
    chk("reset_imm", 64'(immOut), 64'd0);
    chk("reset_tag", 64'(outTag), 64'd0);
    chk("reset_illegal", 64'(outIll), 64'd0);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      drive(vt[k].w, vt[k].s, 32'(k), vt[k].e[31:0], vt[k].il);
      step();
      inValid = 1'b0;
      @(negedge clk);
      chk("latency_one_cycle", 64'(outValid), 64'd1);
      step();
    end
    drain();
    outReady = 1'b0;
    drive(32'h80000000, 3'b000, 32'hAA, 32'hFFFFF800, 1'b0);
    step();
    drive(32'hFFF00093, 3'b000, 32'hBB, 32'hFFFFFFFF, 1'b0);
    step();
    drive(32'h000AD073, 3'b110, 32'hCC, 32'h00000015, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(inReady), 64'd0);
    chk("bp_out_valid", 64'(outValid), 64'd1);
    chk("bp_out_tag_a", 64'(outTag), 64'hAA);
    step();
    @(negedge clk);
    chk("bp_hold_imm", 64'(immOut), 64'hFFFFF800);
    chk("bp_hold_tag", 64'(outTag), 64'hAA);
    chk("bp_still_full", 64'(inReady), 64'd0);
    step();
    outReady = 1'b1;
    step();
    @(negedge clk);
    chk("bp_second_b", 64'(outTag), 64'hBB);
    step();
    inValid = 1'b0;
    @(negedge clk);
    chk("bp_third_c", 64'(outTag), 64'hCC);
    step();
    drain();
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      drive(w, 3'b000, 32'(200 + k), 32'($signed(w) >>> 20), 1'b0);
      @(negedge clk);
      chk("stream_in_ready", 64'(inReady), 64'd1);
      if (k > 0) chk("stream_out_valid", 64'(outValid), 64'd1);
      step();
    end
    inValid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 64'(outValid), 64'd1);
    step();
    drain();
    outReady = 1'b0;
    drive(32'h80000000, 3'b100, 32'h51, 32'h80000000, 1'b0);
    step();
    drive(32'hFFFFFFFF, 3'b111, 32'h52, 32'h0, 1'b1);
    step();
    inValid = 1'b0;
    chk("rst_both_full", 64'(inReady), 64'd0);
    rst_n = 1'b0;
    step();
    chk("rst_mid_out_valid", 64'(outValid), 64'd0);
    chk("rst_mid_in_ready", 64'(inReady), 64'd1);
    chk("rst_mid_imm", 64'(immOut), 64'd0);
    chk("rst_mid_illegal", 64'(outIll), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    outReady = 1'b1;
    drive(32'h7FF00093, 3'b000, 32'h53, 32'h000007FF, 1'b0);
    step();
    inValid = 1'b0;
    @(negedge clk);
    chk("rst_first_latency", 64'(outValid), 64'd1);
    step();
    drain();
    for (int k = 0; k < 5; k++) begin
      v64 = 1'b1;
      instr64 = v6[k].w[31:7];
      src64 = v6[k].s;
      tag64 = 8'(k + 16);
      step();
      v64 = 1'b0;
      @(negedge clk);
      chk("x64_valid", 64'(ov64), 64'd1);
      chk("x64_imm", imm64, v6[k].e);
      chk("x64_tag", 64'(otag64), 64'(k + 16));
      chk("x64_illegal", 64'(ill64), 64'(v6[k].il));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
